norm_sum_hub: RTL and testbench

Single-clock partial-sum reduction hub for the normalization path. It generalises the two-core cross-connected sum exchange to `ncore` cores. Each core pushes signed partial sums into its own input FIFO. The hub pops one entry from every enabled core, reduces them, and returns per core either the global total or the total of all *other* cores (exclude-self). Instantiated at fullchip level, between the cores' `sum_out` and `sum_in` ports, when all cores share a clock.

---
 rtl/norm_sum_hub.sv | 118 +++++++++++
 tb/tb_norm_sum_hub.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_sum_hub.sv
// Partial-sum reduction hub: one input FIFO per core, pops a group from all enabled
// cores at once and returns the global total (or total minus own contribution) per core.
module norm_sum_hub #(
    parameter int ncore  = 4,
    parameter int bw_sum = 23,
    parameter int depth  = 8,
    parameter int bw_out = bw_sum + $clog2(ncore)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ncore*bw_sum-1:0] sum_in,
    input  logic [ncore-1:0]        sum_in_valid,
    output logic [ncore-1:0]        sum_in_ready,
    input  logic [ncore-1:0]        core_en,
    input  logic                    excl_self,
    input  logic                    flush,
    output logic [ncore*bw_out-1:0] sum_out,
    output logic                    sum_out_valid,
    input  logic                    sum_out_ready,
    output logic [7:0]              seq
);

    localparam int aw = $clog2(depth);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [bw_sum-1:0]        mem_q    [ncore][depth];
    logic [aw:0]              wr_ptr_q [ncore];
    logic [aw:0]              rd_ptr_q [ncore];
    logic [0:0]               state_q, state_d;
    logic [ncore*bw_out-1:0]  sum_out_q, sum_out_d;
    logic [7:0]               seq_q, seq_d;

    logic [ncore-1:0]         full, empty, push;
    logic                     heads_ready, fire;
    logic [bw_sum-1:0]        head_raw [ncore];
    logic signed [bw_out-1:0] head     [ncore];
    logic signed [bw_out-1:0] total;

    // Full when the index bits match but the wrap bits differ.
    always_comb begin
        heads_ready = 1'b1;
        for (int i = 0; i < ncore; i++) begin
            full[i]  = (wr_ptr_q[i][aw] != rd_ptr_q[i][aw]) &&
                       (wr_ptr_q[i][aw-1:0] == rd_ptr_q[i][aw-1:0]);
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            push[i]  = sum_in_valid[i] && !full[i];
            if (core_en[i] && empty[i]) heads_ready = 1'b0;
        end
        fire = (|core_en) && heads_ready && (!sum_out_valid || sum_out_ready);
    end

    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        total     = '0;
        sum_out_d = sum_out_q;
        for (int i = 0; i < ncore; i++) begin
            head_raw[i] = mem_q[i][rd_ptr_q[i][aw-1:0]];
            head[i]     = {{(bw_out-bw_sum){head_raw[i][bw_sum-1]}}, head_raw[i]};
            if (core_en[i]) total = total + head[i];
        end
        if (fire) begin
            for (int i = 0; i < ncore; i++) begin
                if (!core_en[i])    sum_out_d[i*bw_out +: bw_out] = '0;
                else if (excl_self) sum_out_d[i*bw_out +: bw_out] = total - head[i];
                else                sum_out_d[i*bw_out +: bw_out] = total;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (fire) state_d = S_FULL;
            S_FULL:  if (sum_out_ready && !fire) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
        seq_d = seq_q + {7'd0, sum_out_valid && sum_out_ready};
    end

    // NOTE: the storage array has no reset; emptiness is carried by the pointers,
    // so clearing them is enough and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ncore; i++) begin
            if (!reset && !flush && push[i])
                mem_q[i][wr_ptr_q[i][aw-1:0]] <= sum_in[i*bw_sum +: bw_sum];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < ncore; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            state_q   <= S_EMPTY;
            sum_out_q <= '0;
            seq_q     <= '0;
        end else begin
            for (int i = 0; i < ncore; i++) begin
                if (push[i])            wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (fire && core_en[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            end
            state_q   <= state_d;
            sum_out_q <= sum_out_d;
            seq_q     <= seq_d;
        end
    end

    assign sum_in_ready  = ~full;
    assign sum_out_valid = (state_q == S_FULL);
    assign sum_out       = sum_out_q;
    assign seq           = seq_q;

endmodule

// File: tb/tb_norm_sum_hub.sv
// Self-checking bench for norm_sum_hub: queue-based reference model compared every
// cycle, directed scenarios with hand-computed values, and a randomized soak.
module tb_norm_sum_hub;

    localparam int NC = 4;
    localparam int BS = 23;
    localparam int DP = 8;
    localparam int BO = 25;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC*BS-1:0]  sum_in;
    logic [NC-1:0]     sum_in_valid;
    logic [NC-1:0]     sum_in_ready;
    logic [NC-1:0]     core_en;
    logic              excl_self;
    logic              flush;
    logic [NC*BO-1:0]  sum_out;
    logic              sum_out_valid;
    logic              sum_out_ready;
    logic [7:0]        seq;

    int n_pass  = 0;
    int n_total = 0;

    norm_sum_hub #(.ncore(NC), .bw_sum(BS), .depth(DP)) dut (
        .clk          (clk),
        .reset        (reset),
        .sum_in       (sum_in),
        .sum_in_valid (sum_in_valid),
        .sum_in_ready (sum_in_ready),
        .core_en      (core_en),
        .excl_self    (excl_self),
        .flush        (flush),
        .sum_out      (sum_out),
        .sum_out_valid(sum_out_valid),
        .sum_out_ready(sum_out_ready),
        .seq          (seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic signed [63:0] dslice(input int i);
        logic signed [BO-1:0] s;
        s = sum_out[i*BO +: BO];
        return s;
    endfunction

    // Reference model: one queue per core plus the expected output register.
    longint  mq [NC][$];
    longint  exp_out [NC];
    bit      exp_valid;
    int      exp_seq;
    int      results_seen;
    bit      model_live = 1'b0;
    bit      m_fire, m_accept;
    longint  m_tot;
    bit [NC-1:0] m_was_full;

    always @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NC; i++) begin
                mq[i].delete();
                exp_out[i] = 0;
            end
            exp_valid    = 1'b0;
            exp_seq      = 0;
            results_seen = 0;
            model_live   = 1'b1;
        end else begin
            m_accept = exp_valid && sum_out_ready;
            m_fire   = (core_en != 0) && (!exp_valid || sum_out_ready);
            for (int i = 0; i < NC; i++) begin
                if (core_en[i] && mq[i].size() == 0) m_fire = 1'b0;
                m_was_full[i] = (mq[i].size() >= DP);
            end
            if (m_fire) begin
                m_tot = 0;
                for (int i = 0; i < NC; i++) if (core_en[i]) m_tot += mq[i][0];
                for (int i = 0; i < NC; i++) begin
                    if (!core_en[i])    exp_out[i] = 0;
                    else if (excl_self) exp_out[i] = m_tot - mq[i][0];
                    else                exp_out[i] = m_tot;
                end
                for (int i = 0; i < NC; i++) if (core_en[i]) void'(mq[i].pop_front());
                exp_valid = 1'b1;
                results_seen++;
            end else if (m_accept) begin
                exp_valid = 1'b0;
            end
            if (m_accept) exp_seq = (exp_seq + 1) % 256;
            for (int i = 0; i < NC; i++)
                if (sum_in_valid[i] && !m_was_full[i])
                    mq[i].push_back(longint'($signed(sum_in[i*BS +: BS])));
        end
    end

    // Compare process: DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            logic [NC-1:0] rdy;
            for (int i = 0; i < NC; i++) rdy[i] = (mq[i].size() < DP);
            check("cmp_ready", sum_in_ready, rdy);
            check("cmp_valid", sum_out_valid, exp_valid);
            check("cmp_seq",   seq, exp_seq);
            if (exp_valid)
                for (int i = 0; i < NC; i++) check($sformatf("cmp_out%0d", i), dslice(i), exp_out[i]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input int i, input longint v);
        sum_in[i*BS +: BS] = BS'(v);
    endtask

    task automatic push_group(input longint a, input longint b, input longint c,
                              input longint d, input logic [NC-1:0] mask);
        set_in(0, a); set_in(1, b); set_in(2, c); set_in(3, d);
        sum_in_valid = mask;
        tick();
        sum_in_valid = '0;
    endtask

    task automatic pulse(input bit use_reset);
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
    endtask

    task automatic check_slices(input string name, input longint a, input longint b,
                                input longint c, input longint d);
        check({name, "_0"}, dslice(0), a);
        check({name, "_1"}, dslice(1), b);
        check({name, "_2"}, dslice(2), c);
        check({name, "_3"}, dslice(3), d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC*BO-1:0] held;
        int pushed;
        longint g0;
        reset = 1'b1; flush = 1'b0; sum_in = '0; sum_in_valid = '0;
        core_en = '1; excl_self = 1'b0; sum_out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", sum_out_valid, 0);
        check("rst_seq",   seq, 0);
        check("rst_ready", sum_in_ready, 4'hF);
        check("rst_out",   sum_out, 0);
        reset = 1'b0;

        // Basic total, 2-edge latency, seq after acceptance.
        push_group(10, -3, 7, 1, 4'hF);
        check("basic_not_yet", sum_out_valid, 0);
        tick();
        check("basic_valid", sum_out_valid, 1);
        check_slices("basic", 15, 15, 15, 15);
        check("model_basic", exp_out[2], 15);
        tick();
        check("basic_seq", seq, 1);
        check("basic_drained", sum_out_valid, 0);

        // Exclude-self and widest negative input.
        excl_self = 1'b1;
        push_group(10, -3, 7, 1, 4'hF);
        tick();
        check_slices("excl", 5, 18, 8, 14);
        tick();
        excl_self = 1'b0;
        push_group(-(64'sd1 << 22), -(64'sd1 << 22), -(64'sd1 << 22), -(64'sd1 << 22), 4'hF);
        tick();
        check_slices("minval", -(64'sd1 << 24), -(64'sd1 << 24), -(64'sd1 << 24), -(64'sd1 << 24));
        tick();

        // Skew and masking: cores 1 and 3 disabled but fed.
        core_en = 4'b0101;
        push_group(100, 55, 0, -77, 4'b1011);
        for (int k = 0; k < 4; k++) begin
            check("skew_no_out", sum_out_valid, 0);
            tick();
        end
        push_group(0, 0, 23, 0, 4'b0100);
        check("skew_no_out_yet", sum_out_valid, 0);
        tick();
        check("skew_valid", sum_out_valid, 1);
        check_slices("skew", 123, 0, 123, 0);
        check("model_keep1", mq[1].size(), 1);
        tick();
        core_en = 4'hF;
        push_group(1, 0, 2, 0, 4'b0101);
        tick();
        check_slices("retained", -19, -19, -19, -19);
        tick();

        // Backpressure, full FIFOs, dropped push and back-to-back drain.
        pulse(1'b0);
        check("bp_seq0", seq, 0);
        sum_out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) check("bp_full", sum_in_ready, 4'h0);
            for (int i = 0; i < NC; i++) set_in(i, k * 7 - i * 3);
            sum_in_valid = 4'hF;
            tick();
        end
        sum_in_valid = '0;
        g0 = 0 - 3 - 6 - 9;
        held = sum_out;
        for (int k = 0; k < 3; k++) begin
            check("bp_hold", sum_out, held);
            tick();
        end
        check_slices("bp_first", g0, g0, g0, g0);
        sum_out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("bp_b2b", sum_out_valid, 1);
        end
        tick();
        check("bp_done", sum_out_valid, 0);
        check("bp_seq9", seq, 9);

        // Wrap-around: 40 groups with random ready and data.
        pulse(1'b0);
        pushed = 0;
        for (int c = 0; c < 2000 && pushed < 40; c++) begin
            sum_out_ready = ($urandom_range(0, 3) != 0);
            excl_self = $urandom_range(0, 1);
            sum_in_valid = '0;
            if (mq[0].size() < DP && $urandom_range(0, 2) != 0) begin
                for (int i = 0; i < NC; i++) set_in(i, longint'($urandom()));
                sum_in_valid = 4'hF;
                pushed++;
            end
            tick();
        end
        sum_in_valid = '0;
        sum_out_ready = 1'b1;
        for (int c = 0; c < 100 && seq != 8'd40; c++) tick();
        check("wrap_seq40", seq, 40);
        check("wrap_model40", results_seen, 40);

        // Flush, then reset, with 3 entries queued and a result pending.
        for (int r = 0; r < 2; r++) begin
            excl_self = 1'b0;
            sum_out_ready = 1'b0;
            for (int k = 0; k < 4; k++) push_group(k, k, k, k, 4'hF);
            check("mid_valid", sum_out_valid, 1);
            pulse(r == 1);
            check("mid_clr_valid", sum_out_valid, 0);
            check("mid_clr_seq", seq, 0);
            check("mid_clr_ready", sum_in_ready, 4'hF);
            sum_out_ready = 1'b1;
            push_group(5, 6, 7, 8, 4'hF);
            tick();
            check_slices("mid_fresh", 26, 26, 26, 26);
            tick();
        end

        // Randomized soak against the model.
        for (int c = 0; c < 1500; c++) begin
            core_en       = ($urandom_range(0, 15) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            excl_self     = $urandom_range(0, 1);
            sum_out_ready = ($urandom_range(0, 2) != 0);
            sum_in_valid  = 4'($urandom_range(0, 15));
            flush         = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NC; i++) set_in(i, longint'($urandom()));
            tick();
        end
        flush = 1'b0;
        sum_in_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
